// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a req/valid instruction memory and
// loads the IF/ID register, freezing on decode hazards and redirecting on taken branches.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_Detected,
    input  logic        Br_taken,
    input  logic [31:0] Br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic        discard, discard_nxt;
    logic        buf_valid, buf_valid_nxt;
    logic        buf_load;
    logic [31:0] buf_pc, buf_instr;
    logic [31:0] if_id_pc_nxt, if_id_instr_nxt;
    logic        if_id_valid_nxt;
    logic        done, eff_br;
    logic [31:0] br_tgt, pc_inc;
    logic        unused_tgt_lsbs;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign imem_req        = (state == S_REQ);
    assign imem_addr       = req_addr;
    assign done            = imem_req & imem_valid;
    assign eff_br          = Br_taken & ~hazard_Detected;
    assign br_tgt          = word_align(Br_target);
    assign pc_inc          = pc + 32'd4;
    assign unused_tgt_lsbs = ^Br_target[1:0];

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        req_addr_nxt    = req_addr;
        discard_nxt     = discard;
        buf_valid_nxt   = buf_valid;
        buf_load        = 1'b0;
        if_id_pc_nxt    = if_id_pc;
        if_id_instr_nxt = if_id_instr;
        if_id_valid_nxt = if_id_valid;

        if (eff_br) begin
            // Redirect: an in-flight request cannot be cancelled, so it is marked for discard
            if_id_instr_nxt = NOP_INSTR;
            if_id_valid_nxt = 1'b0;
            pc_nxt          = br_tgt;
            buf_valid_nxt   = 1'b0;
            if (state == S_REQ && !done) begin
                discard_nxt = 1'b1;
            end else begin
                req_addr_nxt = br_tgt;
                state_nxt    = S_REQ;
                discard_nxt  = 1'b0;
            end
        end else if (hazard_Detected) begin
            case (state)
                S_IDLE: state_nxt = S_REQ;
                S_REQ: begin
                    if (done) begin
                        if (discard) begin
                            discard_nxt  = 1'b0;
                            req_addr_nxt = pc;
                        end else begin
                            buf_load      = 1'b1;
                            buf_valid_nxt = 1'b1;
                            state_nxt     = S_FULL;
                            pc_nxt        = pc_inc;
                            req_addr_nxt  = pc_inc;
                        end
                    end
                end
                default: ;
            endcase
        end else begin
            if_id_instr_nxt = NOP_INSTR;
            if_id_valid_nxt = 1'b0;
            case (state)
                S_IDLE: state_nxt = S_REQ;
                S_REQ: begin
                    if (done) begin
                        if (discard) begin
                            discard_nxt  = 1'b0;
                            req_addr_nxt = pc;
                        end else begin
                            if_id_pc_nxt    = pc;
                            if_id_instr_nxt = imem_rdata;
                            if_id_valid_nxt = 1'b1;
                            pc_nxt          = pc_inc;
                            req_addr_nxt    = pc_inc;
                        end
                    end
                end
                S_FULL: begin
                    // pc already points past the buffered word, so it is the next fetch address
                    if_id_pc_nxt    = buf_pc;
                    if_id_instr_nxt = buf_instr;
                    if_id_valid_nxt = buf_valid;
                    buf_valid_nxt   = 1'b0;
                    state_nxt       = S_REQ;
                    req_addr_nxt    = pc;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            discard     <= 1'b0;
            buf_valid   <= 1'b0;
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            req_addr    <= req_addr_nxt;
            discard     <= discard_nxt;
            buf_valid   <= buf_valid_nxt;
            if_id_pc    <= if_id_pc_nxt;
            if_id_instr <= if_id_instr_nxt;
            if_id_valid <= if_id_valid_nxt;
        end
    end

    // Buffer payload is qualified by buf_valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_pc    <= pc;
            buf_instr <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency memory returning addr>>2, directed scenarios
// with literal expectations, then randomized hazards/branches/resets against a reference model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard_Detected = 1'b0;
    logic        Br_taken = 1'b0;
    logic [31:0] Br_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    if_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .hazard_Detected(hazard_Detected), .Br_taken(Br_taken), .Br_target(Br_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Instruction memory: word at byte address A is A>>2, with programmable wait states
    int fixed_wait = 0;
    int wait_cnt;
    int cur_wait;

    function automatic int pick_wait();
        return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
    endfunction

    always_comb begin
        imem_valid = imem_req && (wait_cnt >= cur_wait);
        imem_rdata = imem_addr >> 2;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
            cur_wait <= pick_wait();
        end else if (imem_req) begin
            if (imem_valid) begin
                wait_cnt <= 0;
                cur_wait <= pick_wait();
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // Reference model: 0 = idle, 1 = requesting, 2 = holding a fetched word
    int          m_state;
    logic [31:0] m_pc, m_req, m_bpc, m_bi, m_ifpc, m_ifi;
    logic        m_disc, m_ifv;

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_req = 0; m_disc = 0;
        m_ifpc = 0; m_ifi = NOP; m_ifv = 0;
    endtask

    task automatic model_step();
        logic        done, ebr;
        logic [31:0] tgt;
        done = (m_state == 1) && imem_valid;
        ebr  = Br_taken && !hazard_Detected;
        tgt  = Br_target & 32'hFFFF_FFFC;
        if (ebr) begin
            m_ifv = 0; m_ifi = NOP; m_pc = tgt;
            if (m_state == 1 && !done) m_disc = 1;
            else begin m_req = tgt; m_state = 1; m_disc = 0; end
        end else begin
            if (!hazard_Detected) begin m_ifv = 0; m_ifi = NOP; end
            if (m_state == 0) m_state = 1;
            else if (m_state == 2) begin
                if (!hazard_Detected) begin
                    m_ifv = 1; m_ifpc = m_bpc; m_ifi = m_bi; m_state = 1; m_req = m_pc;
                end
            end else if (done) begin
                if (m_disc) begin m_disc = 0; m_req = m_pc; end
                else begin
                    if (hazard_Detected) begin
                        m_bpc = m_pc; m_bi = m_pc >> 2; m_state = 2;
                    end else begin
                        m_ifv = 1; m_ifpc = m_pc; m_ifi = m_pc >> 2;
                    end
                    m_pc = m_pc + 4; m_req = m_pc;
                end
            end
        end
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (rst) model_reset();
        check("m_imem_req", {31'b0, imem_req}, {31'b0, m_state == 1});
        if (m_state == 1) check("m_imem_addr", imem_addr, m_req);
        check("m_if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ifv});
        check("m_if_id_instr", if_id_instr, m_ifi);
        if (m_ifv) check("m_if_id_pc", if_id_pc, m_ifpc);
        if (!rst) model_step();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        // Reset then zero-wait memory
        fixed_wait = 0;
        rst = 1; step(); step();
        rst = 0;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, if_id_valid}, 32'd0);
        check("rst_instr", if_id_instr, NOP);
        step();                                   // E1: first request issued
        check("e1_req", {31'b0, imem_req}, 32'd1);
        check("e1_addr", imem_addr, 32'h0);
        check("e1_valid", {31'b0, if_id_valid}, 32'd0);
        step();                                   // E2
        check("e2_valid", {31'b0, if_id_valid}, 32'd1);
        check("e2_instr", if_id_instr, 32'd0);
        check("e2_addr", imem_addr, 32'h4);
        step();                                   // E3
        check("e3_instr", if_id_instr, 32'd1);
        check("e3_pc", if_id_pc, 32'h4);
        check("e3_addr", imem_addr, 32'h8);

        // Freeze while the fetch of 0x8 completes
        hazard_Detected = 1;
        step();
        check("hz_req", {31'b0, imem_req}, 32'd0);
        check("hz_hold_instr", if_id_instr, 32'd1);
        step(); step();
        check("hz_hold_pc", if_id_pc, 32'h4);
        hazard_Detected = 0;
        fixed_wait = 2;
        step();                                   // buffered word enters IF/ID
        check("hz_rel_instr", if_id_instr, 32'd2);
        check("hz_rel_pc", if_id_pc, 32'h8);
        check("hz_next_addr", imem_addr, 32'hC);
        step();
        check("e8_instr", if_id_instr, 32'd3);

        // Taken branch while 0x10 is pending with 2 wait states
        check("br_pend_addr", imem_addr, 32'h10);
        Br_taken = 1; Br_target = 32'h100;
        step();
        Br_taken = 0;
        check("br_bubble", {31'b0, if_id_valid}, 32'd0);
        check("br_hold_addr", imem_addr, 32'h10);
        step();
        check("br_hold_addr2", imem_addr, 32'h10);
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (if_id_valid) seen = 1;
        end
        if (!seen) timeout("br_target_word");
        else begin
            check("br_tgt_pc", if_id_pc, 32'h100);
            check("br_tgt_instr", if_id_instr, 32'h40);
        end

        // Branch together with hazard is ignored
        hazard_Detected = 1; Br_taken = 1; Br_target = 32'h200;
        step(); step(); step(); step();
        check("brhz_hold_pc", if_id_pc, 32'h100);
        hazard_Detected = 0; Br_taken = 0;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (if_id_valid && if_id_pc != 32'h100) seen = 1;
        end
        if (!seen) timeout("brhz_next_word");
        else begin
            check("brhz_next_pc", if_id_pc, 32'h104);
            check("brhz_next_instr", if_id_instr, 32'h41);
        end

        // Reset in the middle of a slow request
        fixed_wait = 3;
        step(); step();
        rst = 1;
        #1;
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'b0, if_id_valid}, 32'd0);
        check("mid_rst_instr", if_id_instr, NOP);
        step();
        rst = 0;
        step();
        check("mid_rst_addr", imem_addr, 32'h0);
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (if_id_valid) seen = 1;
        end
        if (!seen) timeout("mid_rst_first_word");
        else begin
            check("mid_rst_first_pc", if_id_pc, 32'h0);
            check("mid_rst_first_instr", if_id_instr, 32'h0);
        end

        // Randomized traffic; the model compares every cycle
        fixed_wait = -1;
        for (int i = 0; i < 3000; i++) begin
            hazard_Detected = ($urandom_range(0, 3) == 0);
            Br_taken        = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: Br_target = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
                1: Br_target = $urandom;
                default: Br_target = 32'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 499) == 0) begin
                rst = 1; step(); rst = 0;
            end
            step();
        end
        hazard_Detected = 0; Br_taken = 0;
        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
